// File: rtl/verin_avalon2_pio_pkg.sv
// Shared constants for the Avalon-MM input PIO: register offsets and capture modes.
package verin_avalon2_pio_pkg;

   localparam int unsigned BUS_ADDR_W = 2;
   localparam int unsigned BUS_DATA_W = 32;

   localparam logic [BUS_ADDR_W-1:0] ADDR_DATA    = 2'd0;
   localparam logic [BUS_ADDR_W-1:0] ADDR_IRQMASK = 2'd1;
   localparam logic [BUS_ADDR_W-1:0] ADDR_EDGECAP = 2'd2;
   localparam logic [BUS_ADDR_W-1:0] ADDR_PERIOD  = 2'd3;

   localparam int unsigned EDGE_RISE = 0;
   localparam int unsigned EDGE_FALL = 1;
   localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/verin_avalon2_pio_in_if.sv
// Avalon-MM slave bus for the input PIO (word addressed, write-only strobe, registered read).
interface verin_avalon2_pio_in_if;
   import verin_avalon2_pio_pkg::*;

   logic [BUS_ADDR_W-1:0] address;
   logic                  chipselect;
   logic                  write_n;
   logic [BUS_DATA_W-1:0] writedata;
   logic [BUS_DATA_W-1:0] readdata;

   modport master (output address, chipselect, write_n, writedata, input readdata);
   modport slave  (input address, chipselect, write_n, writedata, output readdata);

endinterface

// File: rtl/verin_avalon2_debounce.sv
// One input bit: two-flop synchroniser followed by a period-programmable debouncer.
module verin_avalon2_debounce #(
   parameter int unsigned DB_WIDTH = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                raw,
   input  logic [DB_WIDTH-1:0] period,
   output logic                db
);

   logic                s1;
   logic                s2;
   logic [DB_WIDTH-1:0] cnt;

   // Synchronise, then accept a new level only after it has been stable for period cycles;
   // the >= compare keeps a lowered period from stranding a counter that is already past it.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1  <= 1'b0;
         s2  <= 1'b0;
         db  <= 1'b0;
         cnt <= '0;
      end else begin
         s1 <= raw;
         s2 <= s1;
         if (s2 == db) begin
            cnt <= '0;
         end else if ((period <= DB_WIDTH'(1)) || (cnt >= (period - DB_WIDTH'(1)))) begin
            db  <= s2;
            cnt <= '0;
         end else begin
            cnt <= cnt + DB_WIDTH'(1);
         end
      end
   end

endmodule

// File: rtl/verin_avalon2_pio_in.sv
// Avalon-MM input PIO: debounced inputs, programmable edge capture, masked level interrupt.
module verin_avalon2_pio_in
   import verin_avalon2_pio_pkg::*;
#(
   parameter int unsigned WIDTH            = 4,
   parameter int unsigned DB_WIDTH         = 16,
   parameter int unsigned DEBOUNCE_DEFAULT = 50000,
   parameter int unsigned EDGE_TYPE        = EDGE_RISE
) (
   input  logic                     clk,
   input  logic                     reset,
   verin_avalon2_pio_in_if.slave    bus,
   input  logic [WIDTH-1:0]         in_port,
   output logic                     irq
);

   logic [WIDTH-1:0]      db;
   logic [WIDTH-1:0]      db_d;
   logic [WIDTH-1:0]      irqmask;
   logic [WIDTH-1:0]      edgecap;
   logic [DB_WIDTH-1:0]   period;

   logic                  wr_c;
   logic [WIDTH-1:0]      rise_c;
   logic [WIDTH-1:0]      fall_c;
   logic [WIDTH-1:0]      edge_c;
   logic [WIDTH-1:0]      clr_c;
   logic [BUS_DATA_W-1:0] rd_mux_c;
   logic                  unused_wdata_c;

   // Per-bit synchroniser and debouncer.
   for (genvar i = 0; i < WIDTH; i++) begin : g_db
      verin_avalon2_debounce #(.DB_WIDTH(DB_WIDTH)) u_db (
         .clk    (clk),
         .reset  (reset),
         .raw    (in_port[i]),
         .period (period),
         .db     (db[i])
      );
   end

   assign wr_c           = bus.chipselect & ~bus.write_n;
   assign rise_c         = db & ~db_d;
   assign fall_c         = ~db & db_d;
   assign clr_c          = (wr_c && (bus.address == ADDR_EDGECAP)) ? bus.writedata[WIDTH-1:0] : '0;
   assign irq            = |(edgecap & irqmask);
   assign unused_wdata_c = ^bus.writedata;

   // Edge vector chosen by the capture mode.
   always_comb begin
      edge_c = rise_c;
      if (EDGE_TYPE == EDGE_FALL) begin
         edge_c = fall_c;
      end else if (EDGE_TYPE == EDGE_ANY) begin
         edge_c = rise_c | fall_c;
      end
   end

   // Read mux; unused upper bits are zero.
   always_comb begin
      rd_mux_c = '0;
      case (bus.address)
         ADDR_DATA:    rd_mux_c = BUS_DATA_W'(db);
         ADDR_IRQMASK: rd_mux_c = BUS_DATA_W'(irqmask);
         ADDR_EDGECAP: rd_mux_c = BUS_DATA_W'(edgecap);
         ADDR_PERIOD:  rd_mux_c = BUS_DATA_W'(period);
         default:      rd_mux_c = '0;
      endcase
   end

   // Registers, edge capture (set beats clear) and registered read data.
   always_ff @(posedge clk) begin
      if (reset) begin
         db_d         <= '0;
         irqmask      <= '0;
         edgecap      <= '0;
         period       <= DB_WIDTH'(DEBOUNCE_DEFAULT);
         bus.readdata <= '0;
      end else begin
         db_d         <= db;
         edgecap      <= (edgecap & ~clr_c) | edge_c;
         bus.readdata <= rd_mux_c;
         if (wr_c && (bus.address == ADDR_IRQMASK)) begin
            irqmask <= bus.writedata[WIDTH-1:0];
         end
         if (wr_c && (bus.address == ADDR_PERIOD)) begin
            period <= bus.writedata[DB_WIDTH-1:0];
         end
      end
   end

endmodule

// File: tb/tb_verin_avalon2_pio_in.sv
// Directed bench: three PIO instances (rise/fall/any capture) sharing bus stimulus and inputs.
module tb_verin_avalon2_pio_in;
   import verin_avalon2_pio_pkg::*;

   logic        clk;
   logic        reset;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [3:0]  in_port;
   logic        irq0, irq1, irq2;
   logic [31:0] rdata [3];
   logic [31:0] d;

   int n_checks;
   int n_errors;

   verin_avalon2_pio_in_if bus0 ();
   verin_avalon2_pio_in_if bus1 ();
   verin_avalon2_pio_in_if bus2 ();

   assign bus0.address = address;  assign bus0.chipselect = chipselect;
   assign bus0.write_n = write_n;  assign bus0.writedata  = writedata;
   assign bus1.address = address;  assign bus1.chipselect = chipselect;
   assign bus1.write_n = write_n;  assign bus1.writedata  = writedata;
   assign bus2.address = address;  assign bus2.chipselect = chipselect;
   assign bus2.write_n = write_n;  assign bus2.writedata  = writedata;
   assign rdata[0] = bus0.readdata;
   assign rdata[1] = bus1.readdata;
   assign rdata[2] = bus2.readdata;

   verin_avalon2_pio_in #(.EDGE_TYPE(EDGE_RISE)) u_dut0 (
      .clk(clk), .reset(reset), .bus(bus0), .in_port(in_port), .irq(irq0));
   verin_avalon2_pio_in #(.EDGE_TYPE(EDGE_FALL)) u_dut1 (
      .clk(clk), .reset(reset), .bus(bus1), .in_port(in_port), .irq(irq1));
   verin_avalon2_pio_in #(.EDGE_TYPE(EDGE_ANY)) u_dut2 (
      .clk(clk), .reset(reset), .bus(bus2), .in_port(in_port), .irq(irq2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] v);
      @(negedge clk);
      address = a; chipselect = 1'b1; write_n = 1'b0; writedata = v;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic rd(input int idx, input logic [1:0] a, output logic [31:0] v);
      @(negedge clk);
      address = a;
      @(negedge clk);
      v = rdata[idx];
   endtask

   initial begin
      n_checks = 0; n_errors = 0;
      reset = 1'b1; address = ADDR_DATA; chipselect = 1'b0; write_n = 1'b1;
      writedata = '0; in_port = '0;

      // Reset state and read latency
      repeat (3) @(negedge clk);
      chk("rst_readdata", rdata[0], 32'd0);
      chk("rst_irq", 32'(irq0), 32'd0);
      reset = 1'b0;
      rd(0, ADDR_DATA, d);    chk("rst_data", d, 32'd0);
      address = ADDR_PERIOD;
      #1 chk("lat_before", rdata[0], 32'd0);
      @(negedge clk);         chk("rst_period", rdata[0], 32'd50000);
      rd(0, ADDR_IRQMASK, d); chk("rst_mask", d, 32'd0);
      rd(0, ADDR_EDGECAP, d); chk("rst_cap", d, 32'd0);

      // Glitch rejection with PERIOD=4
      wr(ADDR_PERIOD, 32'd4);
      @(negedge clk); in_port[0] = 1'b1;
      repeat (3) @(negedge clk);
      in_port[0] = 1'b0;
      repeat (10) @(negedge clk);
      rd(0, ADDR_DATA, d);    chk("glitch_data", d, 32'd0);
      rd(0, ADDR_EDGECAP, d); chk("glitch_cap", d, 32'd0);

      // Stable level: db at 5th edge after first sample, capture one edge later
      wr(ADDR_IRQMASK, 32'd1);
      address = ADDR_DATA; in_port[0] = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         @(posedge clk); #1;
         if (i == 6) begin
            chk("hold_data_e6", rdata[0], 32'd0);
            chk("hold_irq_e6", 32'(irq0), 32'd0);
         end
         if (i == 7) begin
            chk("hold_data_e7", rdata[0], 32'd1);
            chk("hold_irq_e7", 32'(irq0), 32'd1);
         end
      end

      // IRQ masking and clearing
      wr(ADDR_IRQMASK, 32'd0); chk("mask_off_irq", 32'(irq0), 32'd0);
      rd(0, ADDR_EDGECAP, d);  chk("mask_off_cap", d, 32'd1);
      wr(ADDR_IRQMASK, 32'd1); chk("mask_on_irq", 32'(irq0), 32'd1);
      wr(ADDR_EDGECAP, 32'd1); chk("clear_irq", 32'(irq0), 32'd0);

      // Clear and edge on bit 2 in the same cycle: set wins
      @(negedge clk); in_port[2] = 1'b1;
      repeat (6) @(negedge clk);
      address = ADDR_EDGECAP; chipselect = 1'b1; write_n = 1'b0; writedata = 32'd4;
      @(negedge clk); chipselect = 1'b0; write_n = 1'b1;
      rd(0, ADDR_EDGECAP, d);  chk("setwins_cap", d, 32'd4);
      wr(ADDR_EDGECAP, 32'd4);
      rd(0, ADDR_EDGECAP, d);  chk("reclear_cap", d, 32'd0);

      // Capture modes on bit 1
      wr(ADDR_EDGECAP, 32'hF);
      in_port[1] = 1'b1;
      repeat (12) @(negedge clk);
      rd(1, ADDR_EDGECAP, d);  chk("fall_on_rise", d, 32'd0);
      rd(2, ADDR_EDGECAP, d);  chk("any_on_rise", d, 32'd2);
      rd(0, ADDR_EDGECAP, d);  chk("rise_on_rise", d, 32'd2);
      wr(ADDR_EDGECAP, 32'hF);
      in_port[1] = 1'b0;
      repeat (12) @(negedge clk);
      rd(1, ADDR_EDGECAP, d);  chk("fall_on_fall", d, 32'd2);
      rd(2, ADDR_EDGECAP, d);  chk("any_on_fall", d, 32'd2);
      rd(0, ADDR_EDGECAP, d);  chk("rise_on_fall", d, 32'd0);

      // PERIOD lowered from 100 to 2 mid-count on bit 3
      wr(ADDR_PERIOD, 32'd100);
      in_port[3] = 1'b1; address = ADDR_DATA;
      repeat (50) @(negedge clk);
      wr(ADDR_PERIOD, 32'd2);
      address = ADDR_DATA;
      @(negedge clk); chk("lower_pre", rdata[0], 32'h5);
      @(negedge clk); chk("lower_post", rdata[0], 32'hD);

      // Reset mid-count on bit 1
      wr(ADDR_PERIOD, 32'd100);
      in_port[1] = 1'b1;
      repeat (20) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("mid_rst_readdata", rdata[0], 32'd0);
      chk("mid_rst_irq", 32'(irq0), 32'd0);
      rd(0, ADDR_PERIOD, d);  chk("mid_rst_period", d, 32'd50000);
      rd(0, ADDR_DATA, d);    chk("mid_rst_data", d, 32'd0);
      rd(0, ADDR_IRQMASK, d); chk("mid_rst_mask", d, 32'd0);
      rd(0, ADDR_EDGECAP, d); chk("mid_rst_cap", d, 32'd0);

      // Counters restart from zero after reset: inputs high, PERIOD=4 from first edge
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      address = ADDR_PERIOD; chipselect = 1'b1; write_n = 1'b0; writedata = 32'd4;
      @(negedge clk); chipselect = 1'b0; write_n = 1'b1; address = ADDR_DATA;
      repeat (5) @(negedge clk);
      chk("restart_e6", rdata[0], 32'd0);
      @(negedge clk);
      chk("restart_e7", rdata[0], 32'hF);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/verin_avalon2_pio_in.md
Name: verin_avalon2_pio_in

Overview:
Parametrised Avalon-MM input PIO, the successor to the 1-bit push-button port. It samples WIDTH asynchronous inputs (buttons, limit switches, encoder lines of the actuator board) through a synchroniser and a per-bit debouncer. It provides programmable edge capture with an interrupt mask, and drives a level interrupt to the Nios II processor. The register map stays on 4 word addresses, with data at offset 0 as before.

Parameters:
WIDTH, 4, number of input bits (1..32).
DB_WIDTH, 16, width of debounce period register and per-bit counters (1..32).
DEBOUNCE_DEFAULT, 50000, reset value of period register (1 ms at 50 MHz); must fit in DB_WIDTH.
EDGE_TYPE, 0, capture mode: 0 rising, 1 falling, 2 any edge.

Ports:
clk  in  1  system clock; the only clock.
reset  in  1  synchronous, active-high reset.
address  in  2  Avalon word address.
chipselect  in  1  slave select.
write_n  in  1  active-low write strobe.
writedata  in  32  write data.
readdata  out  32  registered read data, zero-extended above WIDTH.
in_port  in  WIDTH  asynchronous raw inputs.
irq  out  1  level interrupt, active high.

Behaviour:
- Register map:
  - 0 DATA: debounced levels, read-only; writes ignored.
  - 1 IRQMASK: R/W, WIDTH bits.
  - 2 EDGECAP: read returns capture bits; write-1-to-clear per bit.
  - 3 PERIOD: R/W, DB_WIDTH bits; writedata is truncated.
- Write strobe = chipselect & ~write_n; a write takes effect at the next clk edge.
- readdata:
  - Registered every cycle from the mux selected by address, independent of chipselect.
  - Read latency is exactly 1 cycle.
  - Unused upper bits read 0.
- Reset (synchronous, reset=1 at a clk edge):
  - readdata=0, sync stages=0, debounced=0, delayed debounced=0, counters=0, IRQMASK=0, EDGECAP=0.
  - PERIOD=DEBOUNCE_DEFAULT, so irq=0.
  - Reset mid-count discards all pending debounce state.
- Synchroniser: 2 flops per bit (s1, s2).
- Debouncer, per bit, with P=PERIOD:
  - If s2==db: cnt<=0.
  - Else if P<=1 or cnt>=P-1: db<=s2, cnt<=0.
  - Else cnt<=cnt+1.
  - A glitch shorter than P cycles never reaches db.
  - The >= compare prevents a stall when PERIOD is lowered mid-count. Counters are not cleared on a PERIOD write.
- Timing: a level first sampled by s1 at edge k appears in db at edge k+1+max(P,1). P=0 and P=1 are identical (no filtering).
- Edge detect:
  - db_d <= db each cycle.
  - rise = db & ~db_d; fall = ~db & db_d.
  - The edge vector is selected by EDGE_TYPE.
  - EDGECAP bit sets one edge after db changes, i.e. edge k+2+max(P,1).
- EDGECAP update: cap <= (cap & ~clr) | edge, where clr = writedata[WIDTH-1:0] on a write to address 2. When an edge and a clear hit the same bit in the same cycle, the set wins.
- irq = |(EDGECAP & IRQMASK), registered-source combinational with no extra delay. Masking a set bit drops irq immediately; EDGECAP is unaffected.
- Input high during reset release: db rises after the debounce time and a rising edge is captured (EDGE_TYPE 0/2). This is required behaviour; software clears EDGECAP after init.

Decomposition:
- Package verin_avalon2_pio_pkg: address constants ADDR_DATA=0, ADDR_IRQMASK=1, ADDR_EDGECAP=2, ADDR_PERIOD=3; edge-mode constants EDGE_RISE=0, EDGE_FALL=1, EDGE_ANY=2.
- Sub-module verin_avalon2_debounce: one bit, containing the synchroniser, counter and db output. It is instantiated WIDTH times via generate.
- The top level holds edge detect, registers, read mux and irq.

Test Plan:
1. Reset with in_port=0: after reset, read 3 -> 50000, reads of 0/1/2 -> 0, irq=0. Each read data is valid 1 cycle after address.
2. Bounce rejection, PERIOD=4, WIDTH=4: pulse in_port[0] high for 3 cycles -> DATA stays 0, EDGECAP 0. Hold high for 10 cycles -> DATA=0x1 exactly 5 edges after first sample. EDGECAP bit0 sets 1 cycle later.
3. IRQ path: IRQMASK=0x1 after test 2 -> irq=1. Write 0x1 to EDGECAP -> irq=0 next cycle. Write IRQMASK=0 with a captured bit -> irq=0, EDGECAP still 0x1.
4. Simultaneous clear and edge on bit 2 in the same cycle -> EDGECAP bit2 remains 1.
5. EDGE_TYPE=1 instance: rising edge on bit 1 -> no capture. Falling edge -> EDGECAP=0x2. EDGE_TYPE=2: both edges capture.
6. PERIOD lowered from 100 to 2 while a counter is at 50 -> db updates on the next cycle, with no stall. Assert reset mid-count -> db=0, cnt=0, PERIOD=DEBOUNCE_DEFAULT.
